// File: rtl/fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fb_pkg                                                              |
// | Frame-buffer geometry, pixel formats and RGB565->RGB888 expansion.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fb_pkg;

   localparam int FB_WIDTH     = 240;
   localparam int FB_HEIGHT    = 320;
   localparam int FB_ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT);
   localparam int BRAM_LATENCY = 2;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Replicating the top bits keeps full-scale 565 white at full-scale 888 white.
   function automatic rgb888_t expand565(input rgb565_t p);
      rgb888_t q;
      q.r = {p.r, p.r[4:2]};
      q.g = {p.g, p.g[5:4]};
      q.b = {p.b, p.b[4:2]};
      return q;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_delay                                                          |
// | Fixed-depth shift register with synchronous clear to zero.          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module pipe_delay #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_buffer_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_buffer_reader                                                 |
// | Coordinate -> BRAM address, RGB565 capture/expand, aligned syncs,   |
// | and a vsync-driven frame counter.                                   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module frame_buffer_reader #(
   parameter int FB_WIDTH     = fb_pkg::FB_WIDTH,
   parameter int FB_HEIGHT    = fb_pkg::FB_HEIGHT,
   parameter int BRAM_LATENCY = fb_pkg::BRAM_LATENCY,
   parameter int ADDR_W       = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic              clk_pixel_in,
   input  logic              rst_in,
   input  logic [10:0]       scaled_hcount_in,
   input  logic [9:0]        scaled_vcount_in,
   input  logic              valid_addr_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              active_draw_in,
   output logic [ADDR_W-1:0] addr_out,
   input  logic [15:0]       bram_data_in,
   output logic [23:0]       pixel_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              active_draw_out,
   output logic [7:0]        frame_count_out
);

   import fb_pkg::*;

   localparam int c_PROD_W      = 21;
   localparam int c_FLAG_W      = 4;
   localparam int c_FLAG_VALID  = 3;
   localparam int c_FLAG_HSYNC  = 2;
   localparam int c_FLAG_VSYNC  = 1;
   localparam int c_FLAG_ACTIVE = 0;

   logic [ADDR_W-1:0]   r_addr;
   logic [c_FLAG_W-1:0] r_a_flags;
   logic [c_FLAG_W-1:0] w_b_flags;
   rgb565_t             w_word;
   rgb888_t             r_pixel;
   logic                r_hsync;
   logic                r_vsync;
   logic                r_active;
   logic                r_vsync_prev;
   logic [7:0]          r_frame_count;

   // Stage A: register the read address together with the strobes it belongs to.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         r_addr    <= '0;
         r_a_flags <= '0;
      end else begin
         if (valid_addr_in) begin
            r_addr <= ADDR_W'(c_PROD_W'(scaled_vcount_in) * c_PROD_W'(FB_WIDTH)
                              + c_PROD_W'(scaled_hcount_in));
         end else begin
            r_addr <= '0;
         end
         r_a_flags <= {valid_addr_in, hsync_in, vsync_in, active_draw_in};
      end
   end

   // Stage B: strobes travel alongside the BRAM read for exactly its latency.
   pipe_delay #(
      .WIDTH (c_FLAG_W),
      .DEPTH (BRAM_LATENCY)
   ) u_align (
      .clk    (clk_pixel_in),
      .rst    (rst_in),
      .i_data (r_a_flags),
      .o_data (w_b_flags)
   );

   assign w_word = rgb565_t'(bram_data_in);

   // Stage C: output register; blanked or invalid pixels are forced black.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         r_pixel  <= '0;
         r_hsync  <= 1'b0;
         r_vsync  <= 1'b0;
         r_active <= 1'b0;
      end else begin
         if (w_b_flags[c_FLAG_VALID] && w_b_flags[c_FLAG_ACTIVE]) begin
            r_pixel <= expand565(w_word);
         end else begin
            r_pixel <= '0;
         end
         r_hsync  <= w_b_flags[c_FLAG_HSYNC];
         r_vsync  <= w_b_flags[c_FLAG_VSYNC];
         r_active <= w_b_flags[c_FLAG_ACTIVE];
      end
   end

   // The previous-vsync register follows vsync_in even during reset, so a
   // sync pulse already in progress at release is not seen as a new frame.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         r_frame_count <= '0;
         r_vsync_prev  <= vsync_in;
      end else begin
         r_vsync_prev <= vsync_in;
         if (vsync_in && !r_vsync_prev) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   assign addr_out        = r_addr;
   assign pixel_out       = r_pixel;
   assign hsync_out       = r_hsync;
   assign vsync_out       = r_vsync;
   assign active_draw_out = r_active;
   assign frame_count_out = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_frame_buffer_reader                                              |
// | Directed stimulus with a cycle-by-cycle reference model.            |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_frame_buffer_reader;

   localparam int HIST = 8192;
   localparam int AMAX = 131072;

   logic        clk_pixel_in = 1'b0;
   logic        rst_in;
   logic [10:0] scaled_hcount_in;
   logic [9:0]  scaled_vcount_in;
   logic        valid_addr_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        active_draw_in;
   logic [16:0] addr_out;
   logic [15:0] bram_data_in;
   logic [23:0] pixel_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        active_draw_out;
   logic [7:0]  frame_count_out;

   frame_buffer_reader dut (
      .clk_pixel_in     (clk_pixel_in),
      .rst_in           (rst_in),
      .scaled_hcount_in (scaled_hcount_in),
      .scaled_vcount_in (scaled_vcount_in),
      .valid_addr_in    (valid_addr_in),
      .hsync_in         (hsync_in),
      .vsync_in         (vsync_in),
      .active_draw_in   (active_draw_in),
      .addr_out         (addr_out),
      .bram_data_in     (bram_data_in),
      .pixel_out        (pixel_out),
      .hsync_out        (hsync_out),
      .vsync_out        (vsync_out),
      .active_draw_out  (active_draw_out),
      .frame_count_out  (frame_count_out)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   // Frame-buffer contents and a two-cycle read port.
   logic [15:0] mem [0:AMAX-1];
   logic [15:0] rd1;
   always @(posedge clk_pixel_in) begin
      rd1          <= mem[addr_out];
      bram_data_in <= rd1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int addr_of(input int x, input int y, input logic v);
      return v ? ((y * 240 + x) % AMAX) : 0;
   endfunction

   function automatic int exp888(input logic [15:0] w);
      int r5, g6, b5;
      r5 = (int'(w) >> 11) & 31;
      g6 = (int'(w) >> 5) & 63;
      b5 = int'(w) & 31;
      return ((r5 * 8 + r5 / 4) << 16) | ((g6 * 4 + g6 / 16) << 8) | (b5 * 8 + b5 / 4);
   endfunction

   // Input history indexed by clock-edge number, plus the frame-count model.
   int   e_cnt = 0;
   logic h_rst [0:HIST-1];
   int   h_x   [0:HIST-1];
   int   h_y   [0:HIST-1];
   logic h_v   [0:HIST-1];
   logic h_hs  [0:HIST-1];
   logic h_vs  [0:HIST-1];
   logic h_ad  [0:HIST-1];
   int   exp_fc = 0;
   logic m_prev = 1'b0;

   always @(posedge clk_pixel_in) begin
      e_cnt            <= e_cnt + 1;
      h_rst[e_cnt + 1] <= rst_in;
      h_x[e_cnt + 1]   <= int'(scaled_hcount_in);
      h_y[e_cnt + 1]   <= int'(scaled_vcount_in);
      h_v[e_cnt + 1]   <= valid_addr_in;
      h_hs[e_cnt + 1]  <= hsync_in;
      h_vs[e_cnt + 1]  <= vsync_in;
      h_ad[e_cnt + 1]  <= active_draw_in;
      m_prev           <= vsync_in;
      if (rst_in)                     exp_fc <= 0;
      else if (vsync_in && !m_prev)   exp_fc <= (exp_fc + 1) % 256;
   end

   // Output after edge e reflects the inputs of edge e-3, unless a reset
   // edge lies anywhere in that window.
   always @(negedge clk_pixel_in) begin : cmp
      int   e, src, a, pix;
      bit   zero;
      logic hs, vs, ad;
      if (e_cnt > 0) begin
         e    = e_cnt;
         zero = (e < 4);
         for (int k = 0; k < 4; k++) begin
            if (e - k >= 1 && h_rst[e - k]) zero = 1'b1;
         end
         chk("addr_out", 32'(addr_out), h_rst[e] ? 32'd0 : 32'(addr_of(h_x[e], h_y[e], h_v[e])));
         if (zero) begin
            pix = 0; hs = 1'b0; vs = 1'b0; ad = 1'b0;
         end else begin
            src = e - 3;
            a   = addr_of(h_x[src], h_y[src], h_v[src]);
            pix = (h_v[src] && h_ad[src]) ? exp888(mem[a]) : 0;
            hs  = h_hs[src]; vs = h_vs[src]; ad = h_ad[src];
         end
         chk("pixel_out", 32'(pixel_out), 32'(pix));
         chk("hsync_out", 32'(hsync_out), 32'(hs));
         chk("vsync_out", 32'(vsync_out), 32'(vs));
         chk("active_draw_out", 32'(active_draw_out), 32'(ad));
         chk("frame_count_out", 32'(frame_count_out), 32'(exp_fc));
      end
   end

   task automatic drive(input logic r, input int x, input int y,
                        input logic v, input logic hs, input logic vs, input logic ad);
      rst_in           = r;
      scaled_hcount_in = 11'(x);
      scaled_vcount_in = 10'(y);
      valid_addr_in    = v;
      hsync_in         = hs;
      vsync_in         = vs;
      active_draw_in   = ad;
   endtask

   task automatic tick();
      @(posedge clk_pixel_in);
      #2;
   endtask

   task automatic probe(input int x, input int y, input logic v, input logic hs,
                        input logic vs, input logic ad, input int exp_a,
                        input logic [23:0] exp_pix, input string tag);
      drive(1'b0, x, y, v, hs, vs, ad);
      tick();
      chk({tag, " addr"}, 32'(addr_out), 32'(exp_a));
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk({tag, " pixel"}, 32'(pixel_out), 32'(exp_pix));
      chk({tag, " hsync"}, 32'(hsync_out), 32'(hs));
      chk({tag, " vsync"}, 32'(vsync_out), 32'(vs));
      chk({tag, " active"}, 32'(active_draw_out), 32'(ad));
   endtask

   initial begin
      for (int i = 0; i < AMAX; i++) mem[i] = 16'((i * 40503) ^ (i >> 3));
      mem[485]   = 16'hF81F;
      mem[76799] = 16'h0841;
      mem[0]     = 16'hFFFF;
      mem[7]     = 16'hFFFF;
      mem[8]     = 16'hFFFF;
      mem[9]     = 16'hFFFF;

      // Reset with random inputs: everything must read zero.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
         chk("reset pixel", 32'(pixel_out), 32'd0);
         chk("reset frame_count", 32'(frame_count_out), 32'd0);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick(); tick();

      // Directed probes; 16'h0841 has green 6'b000010, which expands to 8'h08.
      probe(5,   2,   1'b1, 1'b1, 1'b0, 1'b1, 485,   24'hFF00FF, "p485");
      probe(239, 319, 1'b1, 1'b0, 1'b1, 1'b1, 76799, 24'h080808, "pmax");
      probe(9,   0,   1'b1, 1'b0, 1'b0, 1'b1, 9,     24'hFFFFFF, "white");
      probe(7,   0,   1'b1, 1'b1, 1'b1, 1'b0, 7,     24'h000000, "mask_blank");
      probe(8,   0,   1'b0, 1'b0, 1'b0, 1'b1, 0,     24'h000000, "mask_invalid");

      // Back-to-back random traffic checked by the model every cycle.
      for (int i = 0; i < 200; i++) begin
         logic v;
         v = ($urandom_range(0, 3) != 0);
         if (v) drive(1'b0, int'($urandom_range(0, 239)), int'($urandom_range(0, 319)),
                      1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
         else   drive(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                      1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end

      // Frame counter: 300 five-cycle vsync pulses, wrapping through zero.
      drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int p = 0; p < 300; p++) begin
         for (int c = 0; c < 8; c++) begin
            drive(1'b0, 0, 0, 1'b0, 1'b0, (c < 5), 1'b0);
            tick();
         end
         if (p == 0)   chk("frame_count first", 32'(frame_count_out), 32'd1);
         if (p == 255) chk("frame_count wrap", 32'(frame_count_out), 32'd0);
      end
      chk("frame_count 300", 32'(frame_count_out), 32'd44);

      // One-cycle reset in active video with vsync high across release.
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, int'($urandom_range(0, 239)), int'($urandom_range(0, 319)),
               1'b1, (i == 2), (i >= 4), 1'b1);
         tick();
      end
      drive(1'b1, 17, 33, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk("midreset pixel", 32'(pixel_out), 32'd0);
      chk("midreset addr", 32'(addr_out), 32'd0);
      chk("midreset active", 32'(active_draw_out), 32'd0);
      chk("midreset frame_count", 32'(frame_count_out), 32'd0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, int'($urandom_range(0, 239)), int'($urandom_range(0, 319)),
               1'b1, 1'($urandom), 1'b1, 1'b1);
         tick();
      end
      chk("held vsync not counted", 32'(frame_count_out), 32'd0);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("fresh vsync counted", 32'(frame_count_out), 32'd1);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
